grid_bus_serializer: RTL

GRID_BUS_SERIALIZER -- requirements
Module: grid_bus_serializer

---
 rtl/grid_bus_serializer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/grid_bus_serializer.sv
// Serializes 32-bit global-bus words from a small FIFO into header-led byte frames.
// Optional build macro GRID_SER_CHECKSUM_EN appends an XOR checksum byte to every frame.
module grid_bus_serializer #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] HDR_BYTE   = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] word_in,
    input  logic        word_valid,
    output logic        word_ready,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        frame_start,
    output logic        frame_end,
    output logic [3:0]  fifo_count,
    output logic [7:0]  frames_sent
);

    localparam int               PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [3:0]       DEPTH_C = 4'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
`ifdef GRID_SER_CHECKSUM_EN
        ST_DATA = 2'd2,
        ST_CHK  = 2'd3
`else
        ST_DATA = 2'd2
`endif
    } state_t;

`ifdef GRID_SER_CHECKSUM_EN
    function automatic logic [7:0] xor_bytes(input logic [31:0] w);
        return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    endfunction
`endif

    state_t           state_r, state_s;
    logic [1:0]       idx_r, idx_s;
    logic [31:0]      mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_r, wr_ptr_r;
    logic [3:0]       count_r;
    logic [7:0]       frames_r;
    logic [7:0]       byte_out_r, nbyte_s;
    logic             byte_valid_r, nvalid_s;
    logic             frame_start_r, nstart_s;
    logic             frame_end_r, nend_s;
    logic             push_s, xfer_s, eof_s, more_s;
    logic [31:0]      head_s;

    assign word_ready = (count_r != DEPTH_C);
    assign push_s     = word_valid && word_ready;
    assign xfer_s     = byte_valid_r && byte_ready;
    assign eof_s      = xfer_s && frame_end_r;
    // A word pushed on the end-of-frame cycle counts as "another word" so frames run back to back.
    assign more_s     = (count_r > 4'd1) || push_s;
    assign head_s     = mem_r[rd_ptr_r];

    // Next-state logic for the frame sequencer.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (count_r != 4'd0) state_s = ST_HDR;
                else                 state_s = ST_IDLE;
            end
            ST_HDR: begin
                if (xfer_s) begin
                    state_s = ST_DATA;
                    idx_s   = 2'd0;
                end else begin
                    state_s = ST_HDR;
                end
            end
            ST_DATA: begin
                if (xfer_s) begin
                    if (idx_r == 2'd3) begin
`ifdef GRID_SER_CHECKSUM_EN
                        state_s = ST_CHK;
`else
                        state_s = more_s ? ST_HDR : ST_IDLE;
`endif
                    end else begin
                        idx_s = idx_r + 2'd1;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
`ifdef GRID_SER_CHECKSUM_EN
            ST_CHK: begin
                if (xfer_s) state_s = more_s ? ST_HDR : ST_IDLE;
                else        state_s = ST_CHK;
            end
`endif
            default: state_s = ST_IDLE;
        endcase
    end

    // Output values for the state about to be entered; the head word never changes mid-frame.
    always_comb begin
        nbyte_s  = 8'h00;
        nvalid_s = 1'b0;
        nstart_s = 1'b0;
        nend_s   = 1'b0;
        case (state_s)
            ST_HDR: begin
                nbyte_s  = HDR_BYTE;
                nvalid_s = 1'b1;
                nstart_s = 1'b1;
            end
            ST_DATA: begin
                nbyte_s  = head_s[{idx_s, 3'b000} +: 8];
                nvalid_s = 1'b1;
`ifdef GRID_SER_CHECKSUM_EN
                nend_s   = 1'b0;
`else
                nend_s   = (idx_s == 2'd3);
`endif
            end
`ifdef GRID_SER_CHECKSUM_EN
            ST_CHK: begin
                nbyte_s  = xor_bytes(head_s);
                nvalid_s = 1'b1;
                nend_s   = 1'b1;
            end
`endif
            default: begin
                nbyte_s  = 8'h00;
                nvalid_s = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered byte-side outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            idx_r         <= 2'd0;
            byte_out_r    <= 8'h00;
            byte_valid_r  <= 1'b0;
            frame_start_r <= 1'b0;
            frame_end_r   <= 1'b0;
        end else begin
            state_r       <= state_s;
            idx_r         <= idx_s;
            byte_out_r    <= nbyte_s;
            byte_valid_r  <= nvalid_s;
            frame_start_r <= nstart_s;
            frame_end_r   <= nend_s;
        end
    end

    // Word FIFO storage and pointers; the head pops on the end-of-frame transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 32'h0000_0000;
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= word_in;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (eof_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
    end

    // Occupancy and completed-frame counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r  <= 4'd0;
            frames_r <= 8'd0;
        end else begin
            case ({push_s, eof_s})
                2'b10:   count_r <= count_r + 4'd1;
                2'b01:   count_r <= count_r - 4'd1;
                default: count_r <= count_r;
            endcase
            if (eof_s) frames_r <= frames_r + 8'd1;
        end
    end

    assign byte_out    = byte_out_r;
    assign byte_valid  = byte_valid_r;
    assign frame_start = frame_start_r;
    assign frame_end   = frame_end_r;
    assign fifo_count  = count_r;
    assign frames_sent = frames_r;

endmodule
